// File: rtl/aes_sbox_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_sbox_arbiter: shares one 4-byte S-box between encipher and key       |
// | expansion. Optional AES_SBOX_ARB_RR_EN selects round-robin arbitration.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes_sbox_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [31:0] word0,
    input  logic        req1,
    input  logic [31:0] word1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] result,
    output logic [31:0] sboxw,
    input  logic [31:0] new_sboxw,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   grant_sel;

    always_comb begin
        grant_sel = 1'b0;
        if (req0 && req1) begin
`ifdef AES_SBOX_ARB_RR_EN
            grant_sel = ~last_grant;
`else
            // fixed priority: last_grant is tracked but never consulted
            grant_sel = 1'b0 & last_grant;
`endif
        end else if (req1) begin
            grant_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sboxw      <= 32'h0000_0000;
            result     <= 32'h0000_0000;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        sboxw      <= grant_sel ? word1 : word0;
                        busy       <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    result <= new_sboxw;
                    ack0   <= ~owner;
                    ack1   <= owner;
                    state  <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_arbiter.sv
`default_nettype none
// Bench for aes_sbox_arbiter: transaction-timing model plus directed literal checks.
module tb_aes_sbox_arbiter;

`ifdef AES_SBOX_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] word0 = '0, word1 = '0;
    logic        ack0, ack1, busy;
    logic [31:0] result, sboxw, new_sboxw;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    logic [7:0] sbox_tab [0:255] = '{
        'h63,'h7c,'h77,'h7b,'hf2,'h6b,'h6f,'hc5,'h30,'h01,'h67,'h2b,'hfe,'hd7,'hab,'h76,
        'hca,'h82,'hc9,'h7d,'hfa,'h59,'h47,'hf0,'had,'hd4,'ha2,'haf,'h9c,'ha4,'h72,'hc0,
        'hb7,'hfd,'h93,'h26,'h36,'h3f,'hf7,'hcc,'h34,'ha5,'he5,'hf1,'h71,'hd8,'h31,'h15,
        'h04,'hc7,'h23,'hc3,'h18,'h96,'h05,'h9a,'h07,'h12,'h80,'he2,'heb,'h27,'hb2,'h75,
        'h09,'h83,'h2c,'h1a,'h1b,'h6e,'h5a,'ha0,'h52,'h3b,'hd6,'hb3,'h29,'he3,'h2f,'h84,
        'h53,'hd1,'h00,'hed,'h20,'hfc,'hb1,'h5b,'h6a,'hcb,'hbe,'h39,'h4a,'h4c,'h58,'hcf,
        'hd0,'hef,'haa,'hfb,'h43,'h4d,'h33,'h85,'h45,'hf9,'h02,'h7f,'h50,'h3c,'h9f,'ha8,
        'h51,'ha3,'h40,'h8f,'h92,'h9d,'h38,'hf5,'hbc,'hb6,'hda,'h21,'h10,'hff,'hf3,'hd2,
        'hcd,'h0c,'h13,'hec,'h5f,'h97,'h44,'h17,'hc4,'ha7,'h7e,'h3d,'h64,'h5d,'h19,'h73,
        'h60,'h81,'h4f,'hdc,'h22,'h2a,'h90,'h88,'h46,'hee,'hb8,'h14,'hde,'h5e,'h0b,'hdb,
        'he0,'h32,'h3a,'h0a,'h49,'h06,'h24,'h5c,'hc2,'hd3,'hac,'h62,'h91,'h95,'he4,'h79,
        'he7,'hc8,'h37,'h6d,'h8d,'hd5,'h4e,'ha9,'h6c,'h56,'hf4,'hea,'h65,'h7a,'hae,'h08,
        'hba,'h78,'h25,'h2e,'h1c,'ha6,'hb4,'hc6,'he8,'hdd,'h74,'h1f,'h4b,'hbd,'h8b,'h8a,
        'h70,'h3e,'hb5,'h66,'h48,'h03,'hf6,'h0e,'h61,'h35,'h57,'hb9,'h86,'hc1,'h1d,'h9e,
        'he1,'hf8,'h98,'h11,'h69,'hd9,'h8e,'h94,'h9b,'h1e,'h87,'he9,'hce,'h55,'h28,'hdf,
        'h8c,'ha1,'h89,'h0d,'hbf,'he6,'h42,'h68,'h41,'h99,'h2d,'h0f,'hb0,'h54,'hbb,'h16
    };

    function automatic logic [31:0] sb32(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    always_comb new_sboxw = sb32(sboxw);

    aes_sbox_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .word0(word0), .req1(req1), .word1(word1),
        .ack0(ack0), .ack1(ack1), .result(result), .sboxw(sboxw),
        .new_sboxw(new_sboxw), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant at edge g shows sboxw after g, ack/result after g+1,
    // and the next grant may happen no earlier than edge g+3.
    logic        m_ack0 = 1'b0, m_ack1 = 1'b0, m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    logic [31:0] m_sboxw = '0, m_result = '0;
    int          m_n = 0, m_g = 0;
    bit          m_valid = 1'b0;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return RR_MODE ? !last : 1'b0;
        return r0 ? 1'b0 : 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_valid = 1'b0; m_last = 1'b1; m_sboxw = '0; m_result = '0;
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_busy = 1'b0;
        end else begin
            m_n++;
            if ((!m_valid || (m_n - m_g) >= 3) && (req0 || req1)) begin
                m_owner = pick(req0, req1, m_last);
                m_last  = m_owner;
                m_g     = m_n;
                m_valid = 1'b1;
                m_sboxw = m_owner ? word1 : word0;
            end
            m_busy = m_valid && ((m_n - m_g) <= 1);
            m_ack0 = m_valid && ((m_n - m_g) == 1) && !m_owner;
            m_ack1 = m_valid && ((m_n - m_g) == 1) && m_owner;
            if (m_valid && (m_n - m_g) == 1) m_result = sb32(m_sboxw);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("ack0", {31'b0, ack0}, {31'b0, m_ack0});
            check("ack1", {31'b0, ack1}, {31'b0, m_ack1});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("result", result, m_result);
            check("sboxw", sboxw, m_sboxw);
            check("ack_exclusive", {31'b0, ack0 & ack1}, 32'h0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    int n0, n1, first_ack;

    initial begin
        #2 reset_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("rst_sboxw", sboxw, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'b0, ack0, ack1, busy}, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // single lookup, requester 0
        req0 = 1'b1; word0 = 32'h0001_0203;
        tick();
        check("r028_sboxw", sboxw, 32'h0001_0203);
        check("r028_busy1", {31'b0, busy}, 32'h1);
        tick();
        check("r028_ack0", {31'b0, ack0}, 32'h1);
        check("r028_ack1", {31'b0, ack1}, 32'h0);
        check("r028_result", result, 32'h637c_777b);
        check("m028_result", m_result, 32'h637c_777b);
        req0 = 1'b0;
        tick();
        check("r028_idle", {30'b0, ack0, busy}, 32'h0);

        // single lookup, requester 1; busy exactly two cycles
        req1 = 1'b1; word1 = 32'h5353_5353;
        tick();
        check("r029_busy1", {31'b0, busy}, 32'h1);
        tick();
        check("r029_busy2", {31'b0, busy}, 32'h1);
        check("r029_ack1", {31'b0, ack1}, 32'h1);
        check("r029_result", result, 32'hedededed);
        check("m029_result", m_result, 32'hedededed);
        req1 = 1'b0;
        tick();
        check("r029_busy3", {31'b0, busy}, 32'h0);

        // both held high: arbitration pattern
        pulse_reset();
        req0 = 1'b1; word0 = 32'h1010_1010;
        req1 = 1'b1; word1 = 32'h2020_2020;
        n0 = 0; n1 = 0; first_ack = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack0) begin n0++; if (first_ack < 0) first_ack = 0; end
            if (ack1) begin n1++; if (first_ack < 0) first_ack = 1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("r030_ack0_count", n0, RR_MODE ? 2 : 4);
        check("r030_ack1_count", n1, RR_MODE ? 0 + 2 : 0);
        check("r030_first_ack", first_ack, 0);
        tick(); tick();

        // reset during LOOKUP aborts; request re-arbitrated afterwards
        req0 = 1'b1; word0 = 32'h0102_0304;
        tick();
        check("r031_sboxw", sboxw, 32'h0102_0304);
        reset_n = 1'b0;
        #1;
        check("r031_zero_out", {29'b0, ack0, ack1, busy} | result | sboxw, 32'h0);
        tick();
        check("r031_no_ack0", {31'b0, ack0}, 32'h0);
        reset_n = 1'b1;
        tick();
        check("r031_regrant", sboxw, 32'h0102_0304);
        tick();
        check("r031_ack0", {31'b0, ack0}, 32'h1);
        check("r031_result", result, 32'h7c77_7bf2);

        // req1 raised during RESP, req0 dropped afterwards
        req1 = 1'b1; word1 = 32'h0011_2233;
        tick();
        req0 = 1'b0;
        check("r032_ack0_low", {31'b0, ack0}, 32'h0);
        tick();
        check("r032_sboxw", sboxw, 32'h0011_2233);
        tick();
        check("r032_ack1", {31'b0, ack1}, 32'h1);
        check("r032_no_ack0", {31'b0, ack0}, 32'h0);
        check("r032_result", result, 32'h6382_93c3);
        req1 = 1'b0;
        tick();

        // randomized traffic obeying hold-until-ack, with rare resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                tick();
                if (req0) begin
                    if (ack0) begin
                        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
                        else word0 = $urandom;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; word0 = $urandom;
                end
                if (req1) begin
                    if (ack1) begin
                        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
                        else word1 = $urandom;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; word1 = $urandom;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
